rom_lookup_arbiter: RTL and testbench
=====================================

Name: rom_lookup_arbiter

Overview:
- Shares one combinational lookup ROM (4-bit address, 8-bit data, no clock) between NREQ requesters, e.g. neuron units fetching table values.
- Grants requesters round-robin, drives the ROM address, and registers the ROM output.
- Returns each result with the requester's ID over a valid/ready response channel.
- Sits between the neuron-unit array and the ROM instance. The ROM itself is external; this block is its only address driver.

Parameters:
- NREQ, 4, number of requesters (2..8)
- ADDR_W, 4, ROM address width
- DATA_W, 8, ROM data width
- ID_W, 2, width of rsp_id; must satisfy 2**ID_W >= NREQ

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  NREQ  per-requester lookup request
- req_addr  input  NREQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
- req_ready  output  NREQ  one-hot accept; a request transfers when req_valid[i] and req_ready[i] are both high
- rom_addr  output  ADDR_W  address to the ROM
- rom_data  input  DATA_W  ROM output, combinational from rom_addr
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer accepts the response
- rsp_id  output  ID_W  index of the requester the response belongs to
- rsp_data  output  DATA_W  looked-up value

Behaviour:
- Reset values (asynchronous):
  - state = IDLE; req_ready = 0; rom_addr = 0; rsp_valid = 0; rsp_id = 0; rsp_data = 0
  - priority pointer last = NREQ-1, so requester 0 has first priority after reset.
- FSM states: IDLE, GRANT, READ, RESP.
- IDLE:
  - If any req_valid is high, pick g = the first index with req_valid high, scanning last+1, last+2, … modulo NREQ.
  - Register g; go to GRANT.
  - Otherwise stay in IDLE.
- GRANT (1 cycle):
  - req_ready = one-hot(g), registered output.
  - Latch req_addr[g] into addr_q.
  - rom_addr is driven from addr_q on the next cycle.
  - last <= g.
  - Go to READ.
  - Requesters must hold req_valid and req_addr stable until the accept; a valid may not be withdrawn once raised.
- READ (1 cycle):
  - req_ready = 0; rom_addr = addr_q.
  - At the end of the cycle: rsp_data <= rom_data, rsp_id <= g, rsp_valid <= 1. Go to RESP.
- RESP:
  - Hold rsp_valid, rsp_id and rsp_data stable until rsp_ready = 1.
  - On that edge: rsp_valid <= 0; go to IDLE.
  - Arbitration for the next request starts in the following cycle.
- Latency: the accept (req_ready) occurs 1 cycle after the grant decision. rsp_valid rises 2 cycles after the accept cycle.
- Throughput: at best one lookup per 4 cycles with rsp_ready tied high.
- rom_addr holds its last value outside READ; it never glitches to another requester's address mid-lookup.
- Simultaneous requests: exactly one grant per arbitration. Others wait.
- Fairness: with all requesters continuously active, the grant order is 0,1,2,3,0,…
- Only a single requester active: it is granted every round regardless of the pointer.
- rsp_ready high while rsp_valid is low: ignored.
- Reset mid-operation, any state: an in-flight lookup is discarded with no response. All outputs return to their reset values immediately.
- Data is passed through unmodified. Widths equal the ROM's; no truncation occurs in this block.

Optional Feature:
- Macro: ROM_ARB_STAT_EN.
- When defined, adds output port served_cnt (16 bits) and input port stat_clr (1 bit).
  - served_cnt increments on every completed response handshake (rsp_valid & rsp_ready).
  - It saturates at 0xFFFF and resets to 0 on rst.
  - stat_clr synchronously clears it to 0 and takes priority over the increment.
- When undefined, neither port exists and there is no counter logic.
- Arbitration and timing are identical in both cases.

Test Plan:
- After reset, single request req_valid[0]=1, addr=5, rsp_ready=1 -> req_ready=0001 one cycle after request; rsp_valid 2 cycles later with rsp_id=0, rsp_data=0x25 (37).
- All four requesters valid simultaneously with addrs 2,3,7,9, rsp_ready=1 -> responses in order id 0,1,2,3 with data 6, 11, 135, 9.
- Requester 2 alone issues addr 6 three times back-to-back -> three responses, id=2, data=70 each; no other req_ready bits ever asserted.
- rsp_ready held low 5 cycles during RESP, addr=4 -> rsp_valid/rsp_id/rsp_data stable at 1/id/20 throughout; no new req_ready until the handshake completes.
- rst pulsed during READ -> all outputs 0 immediately, no response emitted; next request is served normally with requester 0 at top priority.
- With ROM_ARB_STAT_EN: 3 completed lookups -> served_cnt=3; stat_clr pulsed in the same cycle as a 4th handshake -> served_cnt=0.

Source files
------------

// File: rtl/rom_lookup_arbiter_if.sv
// rom_lookup_arbiter_if
//   Request/response bundle between the requester array and the ROM lookup
//   arbiter.
//   req_valid [NREQ]        : per-requester lookup request
//   req_addr  [NREQ*ADDR_W] : packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_ready [NREQ]        : one-hot accept from the arbiter
//   rsp_valid / rsp_ready   : response handshake
//   rsp_id    [ID_W]        : requester index owning the response
//   rsp_data  [DATA_W]      : looked-up value
//   master = requester side, slave = arbiter side.
interface rom_lookup_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int ID_W   = 2
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ-1:0]        req_ready;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [DATA_W-1:0]      rsp_data;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/rom_lookup_arbiter.sv
// rom_lookup_arbiter
//   Shares one external combinational lookup ROM between NREQ requesters.
//   Round-robin grant, registered ROM address, registered ROM result returned
//   with the requester ID over a valid/ready channel. One lookup per 4 cycles
//   at best (IDLE -> GRANT -> READ -> RESP).
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : rom_lookup_arbiter_if.slave (request/response channels)
//   rom_addr  : address to the ROM (held between lookups)
//   rom_data  : ROM output, combinational from rom_addr
// Optional (macro ROM_ARB_STAT_EN):
//   stat_clr   : synchronous clear of served_cnt, wins over increment
//   served_cnt : saturating 16-bit count of completed response handshakes
module rom_lookup_arbiter #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int ID_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  rom_lookup_arbiter_if.slave bus,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_data
`ifdef ROM_ARB_STAT_EN
  ,
  input  logic               stat_clr,
  output logic [15:0]        served_cnt
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ID_W-1:0]   g_q, g_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NREQ-1:0]   req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic [ID_W-1:0]   pick;
  logic [ADDR_W-1:0] sel_addr;

  // Round-robin pick: lowest valid index above last wins; otherwise wrap to
  // the lowest valid index at or below last. Descending loops leave the
  // lowest matching index in place.
  always_comb begin
    logic            hi_found, lo_found;
    logic [ID_W-1:0] hi, lo;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi       = '0;
    lo       = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        if (i > int'(last_q)) begin
          hi_found = 1'b1;
          hi       = ID_W'(i);
        end else begin
          lo_found = 1'b1;
          lo       = ID_W'(i);
        end
      end
    end
    pick = hi_found ? hi : lo;
  end

  // Address of the currently granted requester.
  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (ID_W'(i) == g_q) sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    last_d      = last_q;
    addr_d      = addr_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          g_d         = pick;
          req_ready_d = NREQ'(1) << pick;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        // Accept cycle: the requester's address is stable, capture it.
        addr_d      = sel_addr;
        last_d      = g_q;
        req_ready_d = '0;
        state_d     = READ;
      end
      READ: begin
        rsp_data_d  = rom_data;
        rsp_id_d    = g_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      g_q         <= '0;
      last_q      <= ID_W'(NREQ - 1);
      addr_q      <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // addr_q only changes at the end of GRANT, so the ROM address is stable
  // through READ and holds afterwards.
  assign rom_addr      = addr_q;
  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;

`ifdef ROM_ARB_STAT_EN
  logic [15:0] served_cnt_q, served_cnt_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    served_cnt_d = served_cnt_q;
    if (stat_clr)                              served_cnt_d = '0;
    else if (rsp_valid_q && bus.rsp_ready)     served_cnt_d = sat_inc(served_cnt_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) served_cnt_q <= '0;
    else     served_cnt_q <= served_cnt_d;
  end

  assign served_cnt = served_cnt_q;
`endif

endmodule

// File: tb/tb_rom_lookup_arbiter.sv
// tb_rom_lookup_arbiter
//   Directed bench for rom_lookup_arbiter. The external ROM is modelled as
//   data = (2**addr + addr) mod 256; expected values are hand-computed.
//   Inputs change and outputs are sampled on the falling clock edge.
module tb_rom_lookup_arbiter;
  localparam int NREQ   = 4;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int ID_W   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [15:0]       rom_full;
  logic              stat_clr;
`ifdef ROM_ARB_STAT_EN
  logic [15:0]       served_cnt;
`endif

  rom_lookup_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  rom_lookup_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
`ifdef ROM_ARB_STAT_EN
    ,
    .stat_clr   (stat_clr),
    .served_cnt (served_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign rom_full = (16'd1 << rom_addr) + {12'd0, rom_addr};
  assign rom_data = rom_full[7:0];

  int tests = 0;
  int fails = 0;
  logic [ID_W-1:0]   got_id[$];
  logic [DATA_W-1:0] got_data[$];
  logic [NREQ-1:0]   ready_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock: requesters drop valid after their accept, responses are
  // recorded on handshake.
  task automatic tick();
    logic [NREQ-1:0] acc;
    acc = bus.req_valid & bus.req_ready;
    ready_seen = ready_seen | bus.req_ready;
    if (bus.rsp_valid && bus.rsp_ready) begin
      got_id.push_back(bus.rsp_id);
      got_data.push_back(bus.rsp_data);
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = bus.req_valid & ~acc;
  endtask

  task automatic clr_q();
    got_id.delete();
    got_data.delete();
    ready_seen = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.rsp_ready = 1'b0;
    stat_clr = 1'b0;
    clr_q();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_req(input int who, input int addr);
    bus.req_addr[who*ADDR_W +: ADDR_W] = ADDR_W'(addr);
    bus.req_valid[who] = 1'b1;
  endtask

  task automatic wait_rsp(input string tag, input int bound);
    int n = 0;
    while (!bus.rsp_valid && n < bound) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.rsp_valid), 1);
  endtask

  task automatic run_until(input string tag, input int count, input int bound);
    int n = 0;
    while (got_id.size() < count && n < bound) begin
      tick();
      n++;
    end
    chk(tag, got_id.size(), count);
  endtask

  // One requester issues `count` lookups back-to-back.
  task automatic serve(input string tag, input int who, input int addr, input int count);
    int issued = 0;
    int n = 0;
    while (got_id.size() < count && n < 80) begin
      if (!bus.req_valid[who] && issued < count) begin
        set_req(who, addr);
        issued++;
      end
      tick();
      n++;
    end
    chk(tag, got_id.size(), count);
  endtask

  initial begin
    // Reset state and single lookup
    do_reset();
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_id",    32'(bus.rsp_id), 0);
    chk("rst_rsp_data",  32'(bus.rsp_data), 0);
    chk("rst_rom_addr",  32'(rom_addr), 0);
    set_req(0, 5);
    bus.rsp_ready = 1'b1;
    tick();
    chk("t1_accept", 32'(bus.req_ready), 32'b0001);
    tick();
    chk("t1_rom_addr", 32'(rom_addr), 5);
    chk("t1_ready_drop", 32'(bus.req_ready), 0);
    chk("t1_no_rsp_yet", 32'(bus.rsp_valid), 0);
    tick();
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("t1_rsp_id", 32'(bus.rsp_id), 0);
    chk("t1_rsp_data", 32'(bus.rsp_data), 37);
    tick();
    chk("t1_rsp_done", 32'(bus.rsp_valid), 0);
    chk("t1_rom_hold", 32'(rom_addr), 5);

    // All four requesters at once, round-robin order from reset
    do_reset();
    bus.rsp_ready = 1'b1;
    set_req(0, 2);
    set_req(1, 3);
    set_req(2, 7);
    set_req(3, 9);
    run_until("t2_count", 4, 60);
    begin
      logic [7:0] exp_d [4] = '{8'd6, 8'd11, 8'd135, 8'd9};
      for (int i = 0; i < 4 && i < got_id.size(); i++) begin
        chk($sformatf("t2_id%0d", i), 32'(got_id[i]), i);
        chk($sformatf("t2_data%0d", i), 32'(got_data[i]), 32'(exp_d[i]));
      end
    end

    // Single requester 2 served every round
    clr_q();
    serve("t3_count", 2, 6, 3);
    for (int i = 0; i < 3 && i < got_id.size(); i++) begin
      chk($sformatf("t3_id%0d", i), 32'(got_id[i]), 2);
      chk($sformatf("t3_data%0d", i), 32'(got_data[i]), 70);
    end
    chk("t3_ready_seen", 32'(ready_seen), 32'b0100);

    // Back-pressure: response held while rsp_ready is low
    clr_q();
    bus.rsp_ready = 1'b0;
    set_req(1, 4);
    wait_rsp("t4_rsp", 10);
    set_req(3, 0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t4_valid%0d", k), 32'(bus.rsp_valid), 1);
      chk($sformatf("t4_id%0d", k), 32'(bus.rsp_id), 1);
      chk($sformatf("t4_data%0d", k), 32'(bus.rsp_data), 20);
      chk($sformatf("t4_noready%0d", k), 32'(bus.req_ready), 0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("t4_released", 32'(bus.rsp_valid), 0);
    chk("t4_idle_ready", 32'(bus.req_ready), 0);
    tick();
    chk("t4_next_grant", 32'(bus.req_ready), 32'b1000);
    run_until("t4_count", 2, 20);
    if (got_data.size() >= 2) chk("t4_next_data", 32'(got_data[1]), 1);

    // Reset during READ discards the lookup
    do_reset();
    bus.rsp_ready = 1'b1;
    set_req(0, 5);
    tick();
    tick();
    chk("t5_in_read", 32'(rom_addr), 5);
    rst = 1'b1;
    #1;
    chk("t5_rst_ready", 32'(bus.req_ready), 0);
    chk("t5_rst_valid", 32'(bus.rsp_valid), 0);
    chk("t5_rst_id", 32'(bus.rsp_id), 0);
    chk("t5_rst_data", 32'(bus.rsp_data), 0);
    chk("t5_rst_rom", 32'(rom_addr), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = '0;
    repeat (4) tick();
    chk("t5_no_rsp", got_id.size(), 0);
    set_req(1, 2);
    set_req(0, 1);
    tick();
    chk("t5_prio0", 32'(bus.req_ready), 32'b0001);
    run_until("t5_count", 2, 30);
    if (got_id.size() >= 2) begin
      chk("t5_id0", 32'(got_id[0]), 0);
      chk("t5_data0", 32'(got_data[0]), 3);
      chk("t5_id1", 32'(got_id[1]), 1);
      chk("t5_data1", 32'(got_data[1]), 6);
    end

`ifdef ROM_ARB_STAT_EN
    // Served counter and clear priority
    do_reset();
    bus.rsp_ready = 1'b1;
    serve("t6_count", 0, 0, 3);
    chk("t6_served3", 32'(served_cnt), 3);
    bus.rsp_ready = 1'b0;
    set_req(0, 1);
    wait_rsp("t6_rsp4", 10);
    bus.rsp_ready = 1'b1;
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("t6_handshake", 32'(bus.rsp_valid), 0);
    chk("t6_cleared", 32'(served_cnt), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
